// File: rtl/archie_loader_pkg.sv
// Shared types and constants for the ROM image loader: FSM states, byte-lane
// masks and the halfword packing decision.
package archie_loader_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    WRITE   = 2'd2,
    FLUSH   = 2'd3
  } loader_state_t;

  localparam logic [3:0] SEL_LO      = 4'b0011;
  localparam logic [3:0] SEL_HI      = 4'b1100;
  localparam logic [3:0] SEL_ALL     = 4'b1111;
  localparam logic [2:0] CTI_CLASSIC = 3'b000;

  typedef struct packed {
    logic        wr;
    logic [3:0]  sel;
    logic [31:0] dat;
  } pack_t;

  function automatic logic [25:0] word_adr(input logic [25:0] base, input logic [21:0] wa);
    return base + {2'b00, wa, 2'b00};
  endfunction

  // A low halfword is always parked; a high halfword merges with a parked low
  // half of the same word, otherwise it goes out alone on the upper lanes.
  function automatic pack_t pack_halfword(input logic hi, input logic [21:0] wa,
                                          input logic [15:0] dat, input logic buf_valid,
                                          input logic [21:0] buf_wa, input logic [15:0] buf_dat);
    pack_t p;
    p.wr  = 1'b0;
    p.sel = SEL_LO;
    p.dat = {dat, dat};
    if (hi) begin
      p.wr = 1'b1;
      if (buf_valid && (buf_wa == wa)) begin
        p.sel = SEL_ALL;
        p.dat = {dat, buf_dat};
      end else begin
        p.sel = SEL_HI;
      end
    end
    return p;
  endfunction

endpackage

// File: rtl/archie_wb_mux.sv
// Selects who drives the SDRAM Wishbone port: the loader while loading,
// otherwise the core as a pure combinational passthrough.
module archie_wb_mux
  import archie_loader_pkg::*;
(
  input  logic        loading,
  input  logic        core_stb,
  input  logic        core_we,
  input  logic [3:0]  core_sel,
  input  logic [25:0] core_adr,
  input  logic [31:0] core_dat_o,
  input  logic [2:0]  core_cti,
  output logic        core_ack,
  input  logic        ld_stb,
  input  logic [3:0]  ld_sel,
  input  logic [25:0] ld_adr,
  input  logic [31:0] ld_dat,
  output logic        ram_stb,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [25:0] ram_adr,
  output logic [31:0] ram_dat,
  output logic [2:0]  ram_cti,
  input  logic        ram_ack
);

  always_comb begin
    if (loading) begin
      ram_stb  = ld_stb;
      ram_cyc  = ld_stb;
      ram_we   = 1'b1;
      ram_sel  = ld_sel;
      ram_adr  = ld_adr;
      ram_dat  = ld_dat;
      ram_cti  = CTI_CLASSIC;
      core_ack = 1'b0;
    end else begin
      ram_stb  = core_stb;
      ram_cyc  = core_stb;
      ram_we   = core_we;
      ram_sel  = core_sel;
      ram_adr  = core_adr;
      ram_dat  = core_dat_o;
      ram_cti  = core_cti;
      core_ack = ram_ack;
    end
  end

endmodule

// File: rtl/archie_rom_loader.sv
// Packs the hps_io 16-bit ROM stream into 32-bit SDRAM writes and holds the core
// off the bus meanwhile. Optional image checksum under `LOADER_CSUM_EN.
module archie_rom_loader
  import archie_loader_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR = 26'h400000,
  parameter logic [7:0]  DL_INDEX  = 8'd1
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        ioctl_download,
  input  logic [7:0]  ioctl_index,
  input  logic        ioctl_wr,
  input  logic [24:0] ioctl_addr,
  input  logic [15:0] ioctl_dout,
  output logic        ioctl_wait,
  input  logic        core_stb,
  input  logic        core_we,
  input  logic [3:0]  core_sel,
  input  logic [25:0] core_adr,
  input  logic [31:0] core_dat_o,
  input  logic [2:0]  core_cti,
  output logic        core_ack,
  output logic        ram_stb,
  output logic        ram_cyc,
  output logic        ram_we,
  output logic [3:0]  ram_sel,
  output logic [25:0] ram_adr,
  output logic [31:0] ram_dat,
  output logic [2:0]  ram_cti,
  input  logic        ram_ack,
  output logic        loading,
  output logic [31:0] csum
);

  loader_state_t state_reg;
  logic          buf_valid_reg;
  logic [21:0]   buf_wa_reg;
  logic [15:0]   buf_dat_reg;
  logic          pend_valid_reg;
  logic          pend_hi_reg;
  logic [21:0]   pend_wa_reg;
  logic [15:0]   pend_dat_reg;
  logic          stb_reg;
  logic [3:0]    sel_reg;
  logic [25:0]   adr_reg;
  logic [31:0]   dat_reg;
  logic          wait_reg;

  logic          active;
  logic          in_hi;
  logic [21:0]   in_wa;
  logic [15:0]   in_dat;
  pack_t         pk;
  logic          unused_addr_bits;

  assign active           = ioctl_download && (ioctl_index == DL_INDEX);
  assign unused_addr_bits = ^{ioctl_addr[24], ioctl_addr[0]};
  assign loading          = (state_reg != IDLE);
  assign ioctl_wait       = wait_reg;

  // A halfword deferred behind a buffered-low write is replayed from pend_*.
  always_comb begin
    in_hi  = ioctl_addr[1];
    in_wa  = ioctl_addr[23:2];
    in_dat = ioctl_dout;
    if (pend_valid_reg) begin
      in_hi  = pend_hi_reg;
      in_wa  = pend_wa_reg;
      in_dat = pend_dat_reg;
    end
    pk = pack_halfword(in_hi, in_wa, in_dat, buf_valid_reg, buf_wa_reg, buf_dat_reg);
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_reg      <= IDLE;
      stb_reg        <= 1'b0;
      wait_reg       <= 1'b0;
      buf_valid_reg  <= 1'b0;
      pend_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (active) state_reg <= COLLECT;
        end
        COLLECT: begin
          if (!active) begin
            if (buf_valid_reg) begin
              adr_reg       <= word_adr(BASE_ADDR, buf_wa_reg);
              dat_reg       <= {buf_dat_reg, buf_dat_reg};
              sel_reg       <= SEL_LO;
              stb_reg       <= 1'b1;
              buf_valid_reg <= 1'b0;
              state_reg     <= FLUSH;
            end else begin
              state_reg <= IDLE;
            end
          end else if (ioctl_wr) begin
            if (buf_valid_reg && (buf_wa_reg != in_wa)) begin
              adr_reg        <= word_adr(BASE_ADDR, buf_wa_reg);
              dat_reg        <= {buf_dat_reg, buf_dat_reg};
              sel_reg        <= SEL_LO;
              stb_reg        <= 1'b1;
              wait_reg       <= 1'b1;
              buf_valid_reg  <= 1'b0;
              pend_valid_reg <= 1'b1;
              pend_hi_reg    <= in_hi;
              pend_wa_reg    <= in_wa;
              pend_dat_reg   <= in_dat;
              state_reg      <= WRITE;
            end else if (pk.wr) begin
              adr_reg       <= word_adr(BASE_ADDR, in_wa);
              dat_reg       <= pk.dat;
              sel_reg       <= pk.sel;
              stb_reg       <= 1'b1;
              wait_reg      <= 1'b1;
              buf_valid_reg <= 1'b0;
              state_reg     <= WRITE;
            end else begin
              buf_valid_reg <= 1'b1;
              buf_wa_reg    <= in_wa;
              buf_dat_reg   <= in_dat;
            end
          end
        end
        WRITE: begin
          if (ram_ack) begin
            stb_reg <= 1'b0;
            if (pend_valid_reg) begin
              pend_valid_reg <= 1'b0;
              if (pk.wr) begin
                // Deferred high halfword: back-to-back write, hps_io stays held.
                adr_reg <= word_adr(BASE_ADDR, in_wa);
                dat_reg <= pk.dat;
                sel_reg <= pk.sel;
                stb_reg <= 1'b1;
              end else begin
                buf_valid_reg <= 1'b1;
                buf_wa_reg    <= in_wa;
                buf_dat_reg   <= in_dat;
                wait_reg      <= 1'b0;
                state_reg     <= COLLECT;
              end
            end else begin
              wait_reg  <= 1'b0;
              state_reg <= COLLECT;
            end
          end
        end
        FLUSH: begin
          if (ram_ack) begin
            stb_reg   <= 1'b0;
            wait_reg  <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

`ifdef LOADER_CSUM_EN
  logic [31:0] csum_reg;

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      csum_reg <= 32'd0;
    end else if ((state_reg == IDLE) && active) begin
      csum_reg <= 32'd0;
    end else if ((state_reg == COLLECT) && active && ioctl_wr) begin
      csum_reg <= csum_reg + {16'd0, ioctl_dout};
    end
  end

  assign csum = csum_reg;
`else
  assign csum = 32'd0;
`endif

  archie_wb_mux u_mux (
    .loading    (loading),
    .core_stb   (core_stb),
    .core_we    (core_we),
    .core_sel   (core_sel),
    .core_adr   (core_adr),
    .core_dat_o (core_dat_o),
    .core_cti   (core_cti),
    .core_ack   (core_ack),
    .ld_stb     (stb_reg),
    .ld_sel     (sel_reg),
    .ld_adr     (adr_reg),
    .ld_dat     (dat_reg),
    .ram_stb    (ram_stb),
    .ram_cyc    (ram_cyc),
    .ram_we     (ram_we),
    .ram_sel    (ram_sel),
    .ram_adr    (ram_adr),
    .ram_dat    (ram_dat),
    .ram_cti    (ram_cti),
    .ram_ack    (ram_ack)
  );

endmodule

// File: tb/tb_archie_rom_loader.sv
// Directed bench for archie_rom_loader: packing, flush, slow acks, reset
// mid-write and core passthrough. Checksum expectation follows `LOADER_CSUM_EN.
module tb_archie_rom_loader;

  logic        clk_sys = 1'b0;
  logic        reset = 1'b1;
  logic        ioctl_download = 1'b0;
  logic [7:0]  ioctl_index = 8'd0;
  logic        ioctl_wr = 1'b0;
  logic [24:0] ioctl_addr = '0;
  logic [15:0] ioctl_dout = '0;
  logic        ioctl_wait;
  logic        core_stb = 1'b0;
  logic        core_we = 1'b0;
  logic [3:0]  core_sel = 4'd0;
  logic [25:0] core_adr = '0;
  logic [31:0] core_dat_o = '0;
  logic [2:0]  core_cti = 3'd0;
  logic        core_ack;
  logic        ram_stb, ram_cyc, ram_we;
  logic [3:0]  ram_sel;
  logic [25:0] ram_adr;
  logic [31:0] ram_dat;
  logic [2:0]  ram_cti;
  logic        ram_ack;
  logic        loading;
  logic [31:0] csum;

  logic        auto_ack = 1'b1;
  logic        resp_ack = 1'b0;
  logic        man_ack = 1'b0;
  time         last_ack_time = 0;
  time         fall_time = 0;
  int          total = 0;
  int          bad = 0;
  int          core_ack_leak = 0;

  typedef struct {
    logic [25:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;
  wr_t wlog[$];

  assign ram_ack = auto_ack ? resp_ack : man_ack;

  archie_rom_loader dut (
    .clk_sys(clk_sys), .reset(reset),
    .ioctl_download(ioctl_download), .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .core_stb(core_stb), .core_we(core_we), .core_sel(core_sel), .core_adr(core_adr),
    .core_dat_o(core_dat_o), .core_cti(core_cti), .core_ack(core_ack),
    .ram_stb(ram_stb), .ram_cyc(ram_cyc), .ram_we(ram_we), .ram_sel(ram_sel),
    .ram_adr(ram_adr), .ram_dat(ram_dat), .ram_cti(ram_cti), .ram_ack(ram_ack),
    .loading(loading), .csum(csum)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // SDRAM model: one-cycle ack to loader strobes, logging each acked write.
  always begin
    @(posedge clk_sys);
    #1;
    if (resp_ack) begin
      resp_ack = 1'b0;
    end else if (auto_ack && ram_stb && ram_cyc && loading) begin
      wlog.push_back('{ram_adr, ram_dat, ram_sel});
      resp_ack = 1'b1;
      last_ack_time = $time;
    end
  end

  always @(posedge clk_sys) begin
    if (ioctl_wr) chk("wr_while_wait", {31'd0, ioctl_wait}, 32'd0);
  end

  always @(negedge clk_sys) begin
    if (loading && core_ack) core_ack_leak++;
  end

  task automatic wr_pulse(input logic [24:0] addr, input logic [15:0] dat);
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b1; ioctl_addr = addr; ioctl_dout = dat;
    @(posedge clk_sys); #1;
    ioctl_wr = 1'b0;
  endtask

  task automatic hw_write(input logic [24:0] addr, input logic [15:0] dat);
    int n;
    n = 0;
    wr_pulse(addr, dat);
    while (ioctl_wait && n < 100) begin
      @(posedge clk_sys); #1;
      n++;
    end
    if (ioctl_wait) chk("wait_timeout", 32'd1, 32'd0);
  endtask

  task automatic start_dl(input logic [7:0] idx);
    ioctl_index = idx;
    ioctl_download = 1'b1;
    repeat (2) @(posedge clk_sys);
    #1;
  endtask

  task automatic end_dl();
    int n;
    n = 0;
    ioctl_download = 1'b0;
    do begin
      @(posedge clk_sys); #1;
      n++;
    end while (loading && n < 100);
    fall_time = $time;
    if (loading) chk("load_fall_timeout", 32'd1, 32'd0);
  endtask

  task automatic expect_write(input string tag, input logic [25:0] adr,
                              input logic [31:0] dat, input logic [3:0] sel);
    wr_t w;
    chk({tag, "_present"}, {31'd0, wlog.size() > 0}, 32'd1);
    if (wlog.size() > 0) begin
      w = wlog.pop_front();
      $display("%s: write adr=%h dat=%h sel=%b", tag, w.adr, w.dat, w.sel);
      chk({tag, "_adr"}, {6'd0, w.adr}, {6'd0, adr});
      chk({tag, "_dat"}, w.dat, dat);
      chk({tag, "_sel"}, {28'd0, w.sel}, {28'd0, sel});
    end
  endtask

  initial begin
    logic [31:0] exp_csum;
    repeat (3) @(posedge clk_sys);
    #1;
    reset = 1'b0;
    chk("rst_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("rst_stb", {31'd0, ram_stb}, 32'd0);
    chk("rst_loading", {31'd0, loading}, 32'd0);
    chk("rst_csum", csum, 32'd0);

    // 1: four halfwords packed into two full words
    start_dl(8'd1);
    chk("t1_loading", {31'd0, loading}, 32'd1);
    hw_write(25'd0, 16'h1111);
    hw_write(25'd2, 16'h2222);
    hw_write(25'd4, 16'h3333);
    hw_write(25'd6, 16'h4444);
    expect_write("t1_w0", 26'h400000, 32'h22221111, 4'b1111);
    expect_write("t1_w1", 26'h400004, 32'h44443333, 4'b1111);
    end_dl();
`ifdef LOADER_CSUM_EN
    exp_csum = 32'h0000AAAA;
`else
    exp_csum = 32'd0;
`endif
    chk("t1_csum", csum, exp_csum);
    $display("t1 done");

    // 2: odd halfword count, trailing low half goes out through flush
    start_dl(8'd1);
    hw_write(25'd0, 16'h1111);
    hw_write(25'd2, 16'h2222);
    hw_write(25'd4, 16'h3333);
    expect_write("t2_w0", 26'h400000, 32'h22221111, 4'b1111);
    chk("t2_held", wlog.size(), 32'd0);
    end_dl();
    expect_write("t2_flush", 26'h400004, 32'h33333333, 4'b0011);
    chk("t2_fall_lat", 32'(fall_time - last_ack_time), 32'd10);

    // 3: address jump evicts the buffered low half; lone high half
    start_dl(8'd1);
    hw_write(25'd0, 16'hAAAA);
    hw_write(25'd8, 16'hBBBB);
    expect_write("t3_evict", 26'h400000, 32'hAAAAAAAA, 4'b0011);
    chk("t3_held", wlog.size(), 32'd0);
    end_dl();
    expect_write("t3_flush", 26'h400008, 32'hBBBBBBBB, 4'b0011);
    start_dl(8'd1);
    hw_write(25'd2, 16'hCCCC);
    expect_write("t3_hi", 26'h400000, 32'hCCCCCCCC, 4'b1100);
    hw_write(25'h1FFFFFE, 16'h9999);
    expect_write("t3_top", 26'h13FFFFC, 32'h99999999, 4'b1100);
    end_dl();

    // 4: ack held off for 5 cycles
    auto_ack = 1'b0;
    start_dl(8'd1);
    wr_pulse(25'h12, 16'h6666);
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("t4_stb%0d", i), {31'd0, ram_stb}, 32'd1);
      chk($sformatf("t4_adr%0d", i), {6'd0, ram_adr}, 32'h00400010);
      chk($sformatf("t4_dat%0d", i), ram_dat, 32'h66666666);
      chk($sformatf("t4_sel%0d", i), {28'd0, ram_sel}, 32'h0000000C);
      chk($sformatf("t4_wait%0d", i), {31'd0, ioctl_wait}, 32'd1);
      if (i < 5) begin
        @(posedge clk_sys); #1;
      end
    end
    man_ack = 1'b1;
    @(posedge clk_sys); #1;
    man_ack = 1'b0;
    chk("t4_wait_low", {31'd0, ioctl_wait}, 32'd0);
    chk("t4_stb_low", {31'd0, ram_stb}, 32'd0);
    chk("t4_still_loading", {31'd0, loading}, 32'd1);
    $display("t4 done");

    // 5: reset while a write is outstanding, then a stray ack
    wr_pulse(25'h16, 16'h7777);
    chk("t5_stb_pre", {31'd0, ram_stb}, 32'd1);
    reset = 1'b1;
    ioctl_download = 1'b0;
    @(posedge clk_sys); #1;
    reset = 1'b0;
    chk("t5_stb", {31'd0, ram_stb}, 32'd0);
    chk("t5_wait", {31'd0, ioctl_wait}, 32'd0);
    chk("t5_loading", {31'd0, loading}, 32'd0);
    man_ack = 1'b1;
    @(posedge clk_sys); #1;
    man_ack = 1'b0;
    @(posedge clk_sys); #1;
    chk("t5_late_loading", {31'd0, loading}, 32'd0);
    chk("t5_late_stb", {31'd0, ram_stb}, 32'd0);
    chk("t5_late_wait", {31'd0, ioctl_wait}, 32'd0);
    $display("t5 done");

    // 6: core passthrough, core blocked during download, foreign index ignored
    core_stb = 1'b1; core_we = 1'b1; core_sel = 4'b1111;
    core_adr = 26'h123450; core_dat_o = 32'hDEADBEEF; core_cti = 3'b010;
    #1;
    chk("t6_adr", {6'd0, ram_adr}, 32'h00123450);
    chk("t6_dat", ram_dat, 32'hDEADBEEF);
    chk("t6_cyc", {31'd0, ram_cyc}, 32'd1);
    chk("t6_cti", {29'd0, ram_cti}, 32'd2);
    chk("t6_ack0", {31'd0, core_ack}, 32'd0);
    man_ack = 1'b1;
    #1;
    chk("t6_ack1", {31'd0, core_ack}, 32'd1);
    man_ack = 1'b0;
    auto_ack = 1'b1;
    start_dl(8'd1);
    hw_write(25'd2, 16'h1234);
    end_dl();
    expect_write("t6_dl", 26'h400000, 32'h12341234, 4'b1100);
    chk("t6_ack_leak", core_ack_leak, 32'd0);
    core_stb = 1'b0;
    start_dl(8'd3);
    wr_pulse(25'd2, 16'h5555);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("t6_idx3_loading", {31'd0, loading}, 32'd0);
    chk("t6_idx3_wait", {31'd0, ioctl_wait}, 32'd0);
    ioctl_download = 1'b0;
    repeat (2) @(posedge clk_sys);
    chk("t6_idx3_nowrite", wlog.size(), 32'd0);
    $display("t6 done");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
